// File: rtl/alu_pkg.sv
// Shared definitions for the shift arbiter: data width, FSM state
// encoding and the 8-bit bit-reversal helper used for the rotate pass.
package alu_pkg;

    localparam int W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [W-1:0] rev8(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = d[W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_arbiter_sl1.sv
// Combinational 8-bit logical left shifter (SL1).
// Ports:
//   sh_in  [7:0] operand
//   sh_amt [2:0] shift amount, 0..7
//   sh_out [7:0] sh_in << sh_amt, bits past bit 7 discarded
module shift_arbiter_sl1
    import alu_pkg::*;
(
    input  logic [W-1:0] sh_in,
    input  logic [2:0]   sh_amt,
    output logic [W-1:0] sh_out
);

    assign sh_out = sh_in << sh_amt;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sequencer sharing one left shifter between two requesters.
// A plain shift is one shifter pass; a rotate adds a second pass on
// bit-reversed operands, which yields the right-shifted part of the rotate.
// Ports:
//   clk, rst                   clock, async active-high reset
//   req_valid/req_ready [1:0]  per-requester request handshake
//   req_data0/1 [7:0]          operands
//   req_amt0/1  [2:0]          shift amounts
//   req_rot0/1                 1 = rotate left, 0 = logical shift left
//   res_valid/res_ready        result handshake
//   res_data [7:0], res_id     result byte and issuing requester
//   busy                       high whenever the FSM is not idle
// Parameter ROT_EN: 0 turns every rotate request into a plain shift.
//
// state | meaning
// IDLE  | waiting for a request, grants one requester
// PASS1 | shifter computes d << n
// PASS2 | rotate only: shifter computes rev(rev(d) << (8-n)) = d >> (8-n)
// DONE  | result presented until res_ready
module shift_arbiter
    import alu_pkg::*;
#(
    parameter logic ROT_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req_data0,
    input  logic [W-1:0] req_data1,
    input  logic [2:0]   req_amt0,
    input  logic [2:0]   req_amt1,
    input  logic         req_rot0,
    input  logic         req_rot1,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_id,
    output logic         busy
);

    state_t       state_q, state_d;
    logic [W-1:0] op_data_q, op_data_d;
    logic [2:0]   op_amt_q, op_amt_d;
    logic         op_rot_q, op_rot_d;
    logic         op_id_q, op_id_d;
    logic         last_q, last_d;
    logic [W-1:0] acc_q, acc_d;

    logic         grant;
    logic [1:0]   req_ready_c;
    logic [W-1:0] sh_in, sh_out;
    logic [2:0]   sh_amt;

    shift_arbiter_sl1 sl1 (
        .sh_in  (sh_in),
        .sh_amt (sh_amt),
        .sh_out (sh_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_data_q <= '0;
            op_amt_q  <= '0;
            op_rot_q  <= 1'b0;
            op_id_q   <= 1'b0;
            last_q    <= 1'b1;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_data_q <= op_data_d;
            op_amt_q  <= op_amt_d;
            op_rot_q  <= op_rot_d;
            op_id_q   <= op_id_d;
            last_q    <= last_d;
            acc_q     <= acc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_data_d   = op_data_q;
        op_amt_d    = op_amt_q;
        op_rot_d    = op_rot_q;
        op_id_d     = op_id_q;
        last_d      = last_q;
        acc_d       = acc_q;
        req_ready_c = 2'b00;
        sh_in       = op_data_q;
        sh_amt      = op_amt_q;

        // On a tie the requester that did not win last time is granted.
        if (req_valid == 2'b11) begin
            grant = ~last_q;
        end else begin
            grant = req_valid[1];
        end

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready_c[grant] = 1'b1;
                    op_data_d = grant ? req_data1 : req_data0;
                    op_amt_d  = grant ? req_amt1  : req_amt0;
                    op_rot_d  = ROT_EN & (grant ? req_rot1 : req_rot0);
                    op_id_d   = grant;
                    last_d    = grant;
                    state_d   = ST_PASS1;
                end
            end
            ST_PASS1: begin
                acc_d = sh_out;
                if (op_rot_q && (op_amt_q != 3'd0)) begin
                    state_d = ST_PASS2;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_PASS2: begin
                // 8 - n in 3 bits; n is nonzero here so this is 1..7.
                sh_in  = rev8(op_data_q);
                sh_amt = 3'd0 - op_amt_q;
                acc_d  = acc_q | rev8(sh_out);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // req_ready is combinational from req_valid, so it must also be
    // forced low while reset is held.
    assign req_ready = rst ? 2'b00 : req_ready_c;
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = acc_q;
    assign res_id    = op_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [7:0] req_data0, req_data1;
    logic [2:0] req_amt0, req_amt1;
    logic       req_rot0, req_rot1;
    logic       res_ready;

    logic [1:0] req_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_id;
    logic       busy;

    logic [1:0] nr_req_ready;
    logic       nr_res_valid;
    logic [7:0] nr_res_data;
    logic       nr_res_id;
    logic       nr_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.ROT_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_amt0(req_amt0), .req_amt1(req_amt1),
        .req_rot0(req_rot0), .req_rot1(req_rot1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    shift_arbiter #(.ROT_EN(1'b0)) dut_nr (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(nr_req_ready),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_amt0(req_amt0), .req_amt1(req_amt1),
        .req_rot0(req_rot0), .req_rot1(req_rot1),
        .res_valid(nr_res_valid), .res_ready(res_ready),
        .res_data(nr_res_data), .res_id(nr_res_id), .busy(nr_busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b11;
        req_data0 = 8'h00; req_data1 = 8'h00;
        req_amt0 = 3'd0;   req_amt1 = 3'd0;
        req_rot0 = 1'b0;   req_rot1 = 1'b0;
        res_ready = 1'b1;
        step();
        step();
        chk("rst_res_valid", 8'(res_valid), 8'h00);
        chk("rst_res_data",  res_data,      8'h00);
        chk("rst_res_id",    8'(res_id),    8'h00);
        chk("rst_busy",      8'(busy),      8'h00);
        chk("rst_req_ready", 8'(req_ready), 8'h00);
        req_valid = 2'b00;
        rst = 1'b0;

        // Plain shift: 0x81 << 3 = 0x08
        req_valid = 2'b01; req_data0 = 8'h81; req_amt0 = 3'd3; req_rot0 = 1'b0;
        #1;
        chk("shl_ready", 8'(req_ready), 8'h01);
        step();
        req_valid = 2'b00;
        chk("shl_t1_valid", 8'(res_valid), 8'h00);
        chk("shl_t1_busy",  8'(busy),      8'h01);
        chk("shl_t1_ready", 8'(req_ready), 8'h00);
        step();
        chk("shl_t2_valid", 8'(res_valid), 8'h01);
        chk("shl_t2_data",  res_data,      8'h08);
        chk("shl_t2_id",    8'(res_id),    8'h00);
        step();
        chk("shl_idle_busy",  8'(busy),      8'h00);
        chk("shl_idle_valid", 8'(res_valid), 8'h00);

        // Rotate from requester 1: rotl(0x81,3) = 0x0C; without rotate 0x08
        req_valid = 2'b10; req_data1 = 8'h81; req_amt1 = 3'd3; req_rot1 = 1'b1;
        #1;
        chk("rot_ready", 8'(req_ready), 8'h02);
        chk("nr_rot_ready", 8'(nr_req_ready), 8'h02);
        step();
        req_valid = 2'b00;
        chk("rot_t1_valid", 8'(res_valid), 8'h00);
        step();
        chk("rot_t2_valid", 8'(res_valid), 8'h00);
        chk("nr_t2_valid", 8'(nr_res_valid), 8'h01);
        chk("nr_t2_data",  nr_res_data,      8'h08);
        chk("nr_t2_id",    8'(nr_res_id),    8'h01);
        step();
        chk("rot_t3_valid", 8'(res_valid), 8'h01);
        chk("rot_t3_data",  res_data,      8'h0c);
        chk("rot_t3_id",    8'(res_id),    8'h01);
        chk("nr_t3_busy",   8'(nr_busy),   8'h00);
        step();
        chk("rot_idle_busy", 8'(busy), 8'h00);

        // Rotate by zero: 0xA5 comes back unchanged after two cycles
        req_valid = 2'b01; req_data0 = 8'hA5; req_amt0 = 3'd0; req_rot0 = 1'b1;
        #1;
        chk("rot0_ready", 8'(req_ready), 8'h01);
        step();
        req_valid = 2'b00;
        chk("rot0_t1_valid", 8'(res_valid), 8'h00);
        step();
        chk("rot0_t2_valid", 8'(res_valid), 8'h01);
        chk("rot0_t2_data",  res_data,      8'hA5);
        chk("rot0_t2_id",    8'(res_id),    8'h00);
        step();
        chk("rot0_idle_busy", 8'(busy), 8'h00);

        // Backpressure: 0x3C << 2 = 0xF0 held for 5 cycles with res_ready low
        res_ready = 1'b0;
        req_valid = 2'b10; req_data1 = 8'h3C; req_amt1 = 3'd2; req_rot1 = 1'b0;
        #1;
        chk("bp_ready", 8'(req_ready), 8'h02);
        step();
        req_valid = 2'b11;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 8'(res_valid), 8'h01);
            chk("bp_data",  res_data,      8'hF0);
            chk("bp_id",    8'(res_id),    8'h01);
            chk("bp_req_ready", 8'(req_ready), 8'h00);
            if (i < 4) step();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 8'(req_ready), 8'h00);
        step();
        // Back in IDLE with both valid; requester 1 went last, so 0 is granted
        chk("bp_idle_valid", 8'(res_valid), 8'h00);
        chk("bp_idle_busy",  8'(busy),      8'h00);
        chk("bp_idle_grant", 8'(req_ready), 8'h01);
        req_valid = 2'b00;
        #1;

        // Reset during PASS2 of a rotate
        req_valid = 2'b10; req_data1 = 8'h81; req_amt1 = 3'd3; req_rot1 = 1'b1;
        step();
        req_valid = 2'b00;
        step();
        chk("rp2_busy", 8'(busy), 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("rp2_res_valid", 8'(res_valid), 8'h00);
        chk("rp2_res_data",  res_data,      8'h00);
        chk("rp2_res_id",    8'(res_id),    8'h00);
        chk("rp2_busy_rst",  8'(busy),      8'h00);
        req_valid = 2'b11;
        #1;
        chk("rp2_req_ready", 8'(req_ready), 8'h00);
        step();
        chk("rp2_hold_valid", 8'(res_valid), 8'h00);
        rst = 1'b0;

        // Fairness from reset: 0x01<<1 = 0x02 for req0, 0x01<<2 = 0x04 for req1
        req_data0 = 8'h01; req_amt0 = 3'd1; req_rot0 = 1'b0;
        req_data1 = 8'h01; req_amt1 = 3'd2; req_rot1 = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("fair_grant", 8'(req_ready), (k % 2 == 0) ? 8'h01 : 8'h02);
            chk("fair_idle_valid", 8'(res_valid), 8'h00);
            step();
            chk("fair_p1_ready", 8'(req_ready), 8'h00);
            step();
            chk("fair_done_valid", 8'(res_valid), 8'h01);
            chk("fair_done_id",    8'(res_id), (k % 2 == 0) ? 8'h00 : 8'h01);
            chk("fair_done_data",  res_data,   (k % 2 == 0) ? 8'h02 : 8'h04);
            chk("fair_done_ready", 8'(req_ready), 8'h00);
            step();
        end
        req_valid = 2'b00;
        step();
        chk("end_busy", 8'(busy), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Sequencer and arbiter that shares one combinational 8-bit logical left shifter between two requesters. It takes one shift request at a time over valid/ready handshakes, using round-robin when both requesters are valid. A plain shift-left takes one shifter pass. A rotate-left takes two passes through the same left shifter: the second pass works on bit-reversed operands. The block sits between the ALU front-end ports and the shifter and returns a tagged result over a valid/ready output channel.

## Interface
- ROT_EN, 1, enables the rotate-left operation; at 0 the rotate request bit is ignored and the operation is a plain shift.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: requester i's operation is accepted this cycle.
- req_data0, req_data1  in  8  operand for requester 0 and requester 1.
- req_amt0, req_amt1  in  3  shift amount, 0 to 7.
- req_rot0, req_rot1  in  1  1 = rotate left, 0 = logical shift left.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  result byte.
- res_id  out  1  index of the requester that issued the operation.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - grant = the valid requester; if both are valid, the requester that is not `last`.
  - req_ready[grant] = 1, computed combinationally from req_valid. All other req_ready bits are 0.
  - On acceptance, latch op_d, op_n, op_rot (op_rot is forced to 0 when ROT_EN = 0), op_id = grant, and set `last` = grant. Next state PASS1.
- PASS1: shifter input = (op_d, op_n). Set acc = shifter output. Next state PASS2 if op_rot = 1 and op_n ≠ 0; otherwise DONE.
- PASS2: shifter input = (rev8(op_d), 8 − op_n). The amount is 3 bits wide and always in 1..7. Set acc = acc | rev8(shifter output). Next state DONE.
- DONE: res_valid = 1, res_data = acc, res_id = op_id. These outputs hold steady until res_ready = 1; then the next state is IDLE.
- No new request is accepted in DONE, even when res_ready is high; acceptance resumes the following cycle in IDLE.
- req_ready is 0 in every state other than IDLE.
- Arithmetic: all values are 8-bit. Bits shifted past bit 7 are discarded. A rotate result equals (d << n) | (d >> (8 − n)).
- Reset (asynchronous, at any point, including mid-operation):
  - state = IDLE, and any in-flight operation is dropped with no result.
  - res_valid = 0, res_data = 0x00, res_id = 0, busy = 0, req_ready = 0.
  - acc = 0, op_* = 0, last = 1, so requester 0 wins the first tie.

## Timing
- Acceptance at cycle t means IDLE with req_valid[i] & req_ready[i] both high.
- Plain shift, and rotate with amount 0: PASS1 at t+1, res_valid first high at t+2.
- Rotate with amount 1..7: PASS1 at t+1, PASS2 at t+2, res_valid first high at t+3.
- Result handshake at cycle u (DONE with res_ready = 1): IDLE at u+1, where the next acceptance may happen.
- Peak throughput is one operation per 3 cycles for plain shifts and one per 4 cycles for rotates.
- Only one requester is granted per acceptance; a non-granted requester waits with req_ready = 0 and keeps its request valid.

## Structure
- Shared package alu_pkg holds:
  - the state typedef and encodings ST_IDLE = 0, ST_PASS1 = 1, ST_PASS2 = 2, ST_DONE = 3;
  - the function rev8 (8-bit bit reversal);
  - the constant W = 8.
- One sub-module instance: the existing combinational 8-bit left shifter SL1. Its operand and amount are muxed from the FSM state.
- No other hierarchy.

## Test plan
- Plain shift: req0 sends 0x81, amount 3, rot 0, res_ready = 1 → res_data = 0x08, res_id = 0; res_valid is high exactly 2 cycles after acceptance, then busy = 0.
- Rotate: req1 sends 0x81, amount 3, rot 1 → res_data = 0x0C, res_id = 1 at 3 cycles after acceptance. With ROT_EN = 0 the same request gives 0x08 at 2 cycles.
- Rotate by zero: req0 sends 0xA5, amount 0, rot 1 → res_data = 0xA5 at 2 cycles; PASS2 is never entered.
- Fairness: both requesters held valid from reset → grants go 0, 1, 0, 1; each requester's req_ready pulses once per accepted operation.
- Backpressure: res_ready held low for 5 cycles in DONE → res_valid, res_data and res_id stay constant and req_ready = 00 throughout. The result is released on the first cycle res_ready is high.
- Reset in PASS2: assert rst during a rotate → all outputs are at reset values immediately (asynchronously), no result is ever produced, and after release requester 0 wins the first tie.
